// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the 2x2/stride-2 pooling engine.
package cnn_pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH1,
        FLUSH2,
        DONE
    } state_t;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Wide enough for any practical sample width; callers sign-extend in and truncate out.
    localparam int SMAX_W = 64;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_pool2x2_engine_if.sv
// ap_ctrl_hs control plus BRAM-style read/write ports of the pooling engine.
interface cnn_pool2x2_engine_if #(
    parameter int DW     = 16,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 8
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic              pool_mode;
    logic              input_r_ce0;
    logic              input_r_ce1;
    logic [IN_AW-1:0]  input_r_address0;
    logic [IN_AW-1:0]  input_r_address1;
    logic [DW-1:0]     input_r_q0;
    logic [DW-1:0]     input_r_q1;
    logic              output_r_ce0;
    logic              output_r_we0;
    logic [OUT_AW-1:0] output_r_address0;
    logic [DW-1:0]     output_r_d0;

    // Controller / memory side.
    modport master (
        output ap_start, pool_mode, input_r_q0, input_r_q1,
        input  ap_done, ap_idle, ap_ready,
        input  input_r_ce0, input_r_ce1, input_r_address0, input_r_address1,
        input  output_r_ce0, output_r_we0, output_r_address0, output_r_d0
    );

    // Engine side.
    modport slave (
        input  ap_start, pool_mode, input_r_q0, input_r_q1,
        output ap_done, ap_idle, ap_ready,
        output input_r_ce0, input_r_ce1, input_r_address0, input_r_address1,
        output output_r_ce0, output_r_we0, output_r_address0, output_r_d0
    );
endinterface

// File: rtl/pool_pair_reduce.sv
// Combinational reduction of two signed samples: max and widened sum.
// The path not selected by mode is forced to zero so it does not toggle.
module pool_pair_reduce
    import cnn_pool_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic                 i_mode,
    output logic signed [DW-1:0] o_max,
    output logic signed [DW:0]   o_sum
);

    assign o_max = (i_mode == POOL_MAX) ? DW'(smax(SMAX_W'(i_a), SMAX_W'(i_b))) : '0;
    assign o_sum = (i_mode == POOL_AVG) ? ((DW+1)'(i_a) + (DW+1)'(i_b)) : '0;

endmodule

// File: rtl/cnn_pool2x2_engine.sv
// 2x2/stride-2 max/average pooling over a C x H x W feature map.
//
// state  | meaning
// IDLE   | waiting for ap_start; ap_idle high
// RUN    | 2N cycles of paired reads: phase 0 top row, phase 1 bottom row
// FLUSH1 | no reads; last bottom pair in the reduce stage
// FLUSH2 | no reads; last result written
// DONE   | ap_done/ap_ready pulse
module cnn_pool2x2_engine
    import cnn_pool_pkg::*;
#(
    parameter int DW     = 16,
    parameter int C      = 1,
    parameter int H      = 28,
    parameter int W      = 28,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 8
) (
    input logic                ap_clk,
    input logic                ap_rst_n,
    cnn_pool2x2_engine_if.slave bus
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = $clog2(H);
    localparam int XW = $clog2(W);

    if (C < 1 || H < 2 || W < 2 || (H % 2) != 0 || (W % 2) != 0) begin : g_geom_chk
        $error("cnn_pool2x2_engine: bad geometry");
    end
    if ((2**IN_AW) < C*H*W) begin : g_in_aw_chk
        $error("cnn_pool2x2_engine: IN_AW too small");
    end
    if ((2**OUT_AW) < (C*H*W)/4) begin : g_out_aw_chk
        $error("cnn_pool2x2_engine: OUT_AW too small");
    end

    state_t                r_state;
    state_t                w_next;
    logic                  w_idle;
    logic                  w_done;
    logic                  w_rd_en;
    logic                  w_accept;
    logic                  r_mode;
    logic                  r_phase;
    logic [CW-1:0]         r_c;
    logic [RW-1:0]         r_r;
    logic [XW-1:0]         r_x;
    logic                  w_last_x;
    logic                  w_last_r;
    logic                  w_last_c;
    logic                  w_last;
    logic [IN_AW-1:0]      w_addr0;
    logic                  r_top_v;
    logic                  r_bot_v;
    logic                  r_wr_v;
    logic signed [DW:0]    r_part;
    logic [OUT_AW-1:0]     r_wr_addr;
    logic signed [DW-1:0]  r_wr_data;
    logic signed [DW-1:0]  w_q0;
    logic signed [DW-1:0]  w_q1;
    logic signed [DW-1:0]  w_row_max;
    logic signed [DW:0]    w_row_sum;
    logic signed [DW:0]    w_row;
    logic signed [DW:0]    w_fin_max;
    logic signed [DW+1:0]  w_fin_sum;
    logic signed [DW-1:0]  w_result;

    assign w_accept = (r_state == IDLE) && bus.ap_start;
    assign w_last_x = (r_x == XW'(W-2));
    assign w_last_r = (r_r == RW'(H-2));
    assign w_last_c = (r_c == CW'(C-1));
    assign w_last   = r_phase && w_last_x && w_last_r && w_last_c;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // Next-state and control outputs.
    always_comb begin
        w_next  = r_state;
        w_idle  = 1'b0;
        w_done  = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (bus.ap_start) w_next = RUN;
            end
            RUN: begin
                w_rd_en = 1'b1;
                if (w_last) w_next = FLUSH1;
            end
            FLUSH1: w_next = FLUSH2;
            FLUSH2: w_next = DONE;
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Scan position: phase within the pair, then column, row, channel.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_mode  <= POOL_MAX;
            r_phase <= 1'b0;
            r_c     <= '0;
            r_r     <= '0;
            r_x     <= '0;
        end else begin
            if (w_accept) r_mode <= bus.pool_mode;
            if (r_state == RUN) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    if (w_last_x) begin
                        r_x <= '0;
                        if (w_last_r) begin
                            r_r <= '0;
                            r_c <= w_last_c ? '0 : r_c + CW'(1);
                        end else begin
                            r_r <= r_r + RW'(2);
                        end
                    end else begin
                        r_x <= r_x + XW'(2);
                    end
                end
            end
        end
    end

    // Address of the left sample of the current pair; the row below is selected by phase.
    assign w_addr0 = IN_AW'(32'(r_c) * 32'(H*W) + (32'(r_r) + 32'(r_phase)) * 32'(W) + 32'(r_x));

    assign bus.input_r_ce0      = w_rd_en;
    assign bus.input_r_ce1      = w_rd_en;
    assign bus.input_r_address0 = w_rd_en ? w_addr0 : '0;
    assign bus.input_r_address1 = w_rd_en ? (w_addr0 + IN_AW'(1)) : '0;

    assign w_q0 = signed'(bus.input_r_q0);
    assign w_q1 = signed'(bus.input_r_q1);

    pool_pair_reduce #(.DW(DW)) u_row (
        .i_a    (w_q0),
        .i_b    (w_q1),
        .i_mode (r_mode),
        .o_max  (w_row_max),
        .o_sum  (w_row_sum)
    );

    // Max and sum share one DW+1 lane; the mode decides which one it carries.
    assign w_row = (r_mode == POOL_AVG) ? w_row_sum : (DW+1)'(w_row_max);

    pool_pair_reduce #(.DW(DW+1)) u_fin (
        .i_a    (r_part),
        .i_b    (w_row),
        .i_mode (r_mode),
        .o_max  (w_fin_max),
        .o_sum  (w_fin_sum)
    );

    // Arithmetic shift floors toward -inf; the quotient always fits back in DW.
    assign w_result = (r_mode == POOL_AVG) ? DW'(w_fin_sum >>> 2) : DW'(w_fin_max);

    // Read-return pipeline: top pair into the partial, bottom pair into the result, then write.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_top_v   <= 1'b0;
            r_bot_v   <= 1'b0;
            r_wr_v    <= 1'b0;
            r_part    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_top_v <= (r_state == RUN) && !r_phase;
            r_bot_v <= (r_state == RUN) && r_phase;
            r_wr_v  <= r_bot_v;
            if (r_top_v) r_part <= w_row;
            if (r_bot_v) r_wr_data <= w_result;
            if (w_accept)    r_wr_addr <= '0;
            else if (r_wr_v) r_wr_addr <= r_wr_addr + OUT_AW'(1);
        end
    end

    assign bus.output_r_ce0      = r_wr_v;
    assign bus.output_r_we0      = r_wr_v;
    assign bus.output_r_address0 = r_wr_addr;
    assign bus.output_r_d0       = r_wr_data;

    assign bus.ap_idle  = w_idle;
    assign bus.ap_done  = w_done;
    assign bus.ap_ready = w_done;

endmodule

// File: tb/tb_cnn_pool2x2_engine.sv
// Directed bench for cnn_pool2x2_engine with C=2, H=W=4, DW=16.
module tb_cnn_pool2x2_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_pool2x2_engine_if #(.DW(16), .IN_AW(6), .OUT_AW(4)) bus ();

    cnn_pool2x2_engine #(
        .DW(16), .C(2), .H(4), .W(4), .IN_AW(6), .OUT_AW(4)
    ) u_dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave)
    );

    logic [15:0] mem_in  [64];
    logic [15:0] out_mem [16];
    logic [15:0] exp_max [8];

    int cyc = 0;
    int wr_cnt = 0, done_cnt = 0, start_cnt = 0, mon_bad = 0;
    int last_start = 0, prev_start = 0, last_done = 0, prev_done = 0;
    int total = 0, bad = 0;

    // Input memory: registered read, data one cycle after ce.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.input_r_ce0) bus.input_r_q0 <= mem_in[bus.input_r_address0];
        if (bus.input_r_ce1) bus.input_r_q1 <= mem_in[bus.input_r_address1];
    end

    // Mid-cycle observer: output memory, start/done timing, protocol invariants.
    always @(negedge clk) begin
        if (rst_n && bus.ap_idle && bus.ap_start) begin
            prev_start = last_start;
            last_start = cyc;
            start_cnt++;
            for (int i = 0; i < 16; i++) out_mem[i] = 16'hDEAD;
        end
        if (bus.output_r_ce0 && bus.output_r_we0) begin
            out_mem[bus.output_r_address0] = bus.output_r_d0;
            wr_cnt++;
        end
        if (bus.ap_done) begin
            prev_done = last_done;
            last_done = cyc;
            done_cnt++;
        end
        if (bus.output_r_ce0 !== bus.output_r_we0) mon_bad++;
        if (bus.ap_done !== bus.ap_ready) mon_bad++;
        if (bus.input_r_ce0 !== bus.input_r_ce1) mon_bad++;
        if (bus.input_r_ce0 && bus.ap_idle) mon_bad++;
        if (bus.input_r_ce0 && (bus.input_r_address1 !== bus.input_r_address0 + 6'd1)) mon_bad++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            tick(1);
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic start_run(input logic mode);
        bus.pool_mode = mode;
        bus.ap_start  = 1'b1;
        tick(1);
        bus.ap_start  = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) mem_in[i] = 16'(i);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 64; i++) mem_in[i] = 16'h0000;
    endtask

    int d0, w0, s0, w_snap, n;

    initial begin
        exp_max = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd21, 16'd23, 16'd29, 16'd31};
        bus.ap_start  = 1'b0;
        bus.pool_mode = 1'b0;
        fill_ramp();

        // Reset held three cycles.
        rst_n = 1'b0;
        tick(3);
        chk("rst_idle",  32'(bus.ap_idle), 32'd1);
        chk("rst_done",  32'(bus.ap_done), 32'd0);
        chk("rst_ready", 32'(bus.ap_ready), 32'd0);
        chk("rst_we",    32'(bus.output_r_we0), 32'd0);
        chk("rst_ce0",   32'(bus.input_r_ce0), 32'd0);
        chk("rst_ce1",   32'(bus.input_r_ce1), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_idle", 32'(bus.ap_idle), 32'd1);

        // Max mode on a ramp, with a stray start pulse during RUN.
        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b0);
        tick(4);
        bus.ap_start = 1'b1;
        tick(1);
        bus.ap_start = 1'b0;
        wait_done(d0 + 1, 60);
        tick(3);
        for (int k = 0; k < 8; k++) chk($sformatf("max_out%0d", k), 32'(out_mem[k]), 32'(exp_max[k]));
        chk("max_writes",  32'(wr_cnt - w0), 32'd8);
        chk("max_dones",   32'(done_cnt - d0), 32'd1);
        chk("max_latency", 32'(last_done - last_start), 32'd19);
        chk("max_idle_after", 32'(bus.ap_idle), 32'd1);

        // Average mode: rounding toward -inf and the two extremes; mode flipped mid-run.
        fill_zero();
        mem_in[0]  = 16'hFFFF; mem_in[1]  = 16'hFFFE; mem_in[4]  = 16'hFFFD; mem_in[5]  = 16'hFFFC;
        mem_in[2]  = 16'h7FFF; mem_in[3]  = 16'h7FFF; mem_in[6]  = 16'h7FFF; mem_in[7]  = 16'h7FFF;
        mem_in[8]  = 16'h8000; mem_in[9]  = 16'h8000; mem_in[12] = 16'h8000; mem_in[13] = 16'h8000;
        mem_in[10] = 16'd1;    mem_in[11] = 16'd2;    mem_in[14] = 16'd3;    mem_in[15] = 16'd5;
        mem_in[16] = 16'hFFFF;
        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b1);
        tick(6);
        bus.pool_mode = 1'b0;
        wait_done(d0 + 1, 60);
        tick(3);
        chk("avg_neg",   32'(out_mem[0]), 32'h0000FFFD);
        chk("avg_pmax",  32'(out_mem[1]), 32'h00007FFF);
        chk("avg_nmax",  32'(out_mem[2]), 32'h00008000);
        chk("avg_mix",   32'(out_mem[3]), 32'h00000002);
        chk("avg_m1",    32'(out_mem[4]), 32'h0000FFFF);
        chk("avg_zero",  32'(out_mem[7]), 32'h00000000);
        chk("avg_writes", 32'(wr_cnt - w0), 32'd8);

        // Max mode on negative values; mode flipped to average mid-run.
        fill_zero();
        mem_in[0] = 16'hFFFB; mem_in[1] = 16'hFFFF; mem_in[4] = 16'hFFF9; mem_in[5] = 16'hFFFD;
        mem_in[2] = 16'h8000; mem_in[3] = 16'h8000; mem_in[6] = 16'h8000; mem_in[7] = 16'h8001;
        d0 = done_cnt;
        start_run(1'b0);
        tick(6);
        bus.pool_mode = 1'b1;
        wait_done(d0 + 1, 60);
        tick(3);
        chk("neg_max0", 32'(out_mem[0]), 32'h0000FFFF);
        chk("neg_max1", 32'(out_mem[1]), 32'h00008001);
        chk("neg_max5", 32'(out_mem[5]), 32'h00000000);

        // Reset in RUN cycle 6: two writes have landed, none after the reset edge.
        fill_ramp();
        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b0);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_idle",   32'(bus.ap_idle), 32'd1);
        chk("midrst_we",     32'(bus.output_r_we0), 32'd0);
        chk("midrst_ce",     32'(bus.input_r_ce0), 32'd0);
        w_snap = wr_cnt;
        chk("midrst_pre_writes", 32'(w_snap - w0), 32'd2);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk("midrst_no_writes", 32'(wr_cnt - w_snap), 32'd0);
        chk("midrst_no_done",   32'(done_cnt - d0), 32'd0);

        // Fresh run after the aborted one.
        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b0);
        wait_done(d0 + 1, 60);
        tick(3);
        for (int k = 0; k < 8; k++) chk($sformatf("rerun_out%0d", k), 32'(out_mem[k]), 32'(exp_max[k]));
        chk("rerun_writes", 32'(wr_cnt - w0), 32'd8);

        // ap_start held high across two runs.
        d0 = done_cnt; w0 = wr_cnt; s0 = start_cnt;
        bus.pool_mode = 1'b0;
        bus.ap_start  = 1'b1;
        n = 0;
        while (start_cnt < s0 + 2 && n < 80) begin
            tick(1);
            n++;
        end
        bus.ap_start = 1'b0;
        chk("b2b_starts", 32'(start_cnt - s0), 32'd2);
        wait_done(d0 + 2, 60);
        tick(3);
        chk("b2b_dones",   32'(done_cnt - d0), 32'd2);
        chk("b2b_writes",  32'(wr_cnt - w0), 32'd16);
        chk("b2b_gap",     32'(last_start - prev_done), 32'd1);
        chk("b2b_period",  32'(last_start - prev_start), 32'd20);
        chk("b2b_latency", 32'(last_done - last_start), 32'd19);
        chk("b2b_out0",    32'(out_mem[0]), 32'd5);
        chk("b2b_out7",    32'(out_mem[7]), 32'd31);

        chk("protocol_monitor", 32'(mon_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
